// File: rtl/router_pkg.sv
// Shared router constants: data width, FIFO depth, header field layout and
// the header-to-byte-count helper used by the output FIFOs.
package router_pkg;

    localparam int ROUTER_DATA_W     = 8;
    localparam int ROUTER_FIFO_DEPTH = 16;
    localparam int ROUTER_LEN_W      = 6;

    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    // Bytes still to come after a header: payload length plus the parity byte.
    function automatic logic [ROUTER_LEN_W:0] hdr_pkt_count(input logic [ROUTER_DATA_W-1:0] hdr);
        return {1'b0, hdr[HDR_LEN_MSB:HDR_LEN_LSB]} + {{ROUTER_LEN_W{1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Register array with one write port, one combinational read port and
// asynchronous/synchronous clear of every word.
module router_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int DW    = 9,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [DEPTH];

    // Storage words: wiped on either reset so no stale header flag survives.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/router_fifo.sv
// Router output FIFO: stores {header flag, byte}, tracks the packet byte count
// on reads and zeroes data_out between packets.
// Optional feature: define ROUTER_FIFO_ALMOST_FULL_EN to add the almost_full output.
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = ROUTER_FIFO_DEPTH,
    parameter int WIDTH = ROUTER_DATA_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
`ifdef ROUTER_FIFO_ALMOST_FULL_EN
    output logic             empty,
    output logic             almost_full
`else
    output logic             empty
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]           PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [ROUTER_LEN_W:0] CNT_ONE = {{ROUTER_LEN_W{1'b0}}, 1'b1};

    logic [AW:0]           wr_ptr_r;
    logic [AW:0]           rd_ptr_r;
    logic [ROUTER_LEN_W:0] pkt_cnt_r;
    logic [WIDTH:0]        rd_word_s;
    logic                  wr_fire_s;
    logic                  rd_fire_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign wr_fire_s = write_enb && !full;
    assign rd_fire_s = read_enb && !empty;

`ifdef ROUTER_FIFO_ALMOST_FULL_EN
    localparam logic [AW:0] AF_LEVEL = (AW+1)'(DEPTH - 2);
    logic [AW:0] occupancy_s;
    assign occupancy_s = wr_ptr_r - rd_ptr_r;
    assign almost_full = (occupancy_s >= AF_LEVEL);
`endif

    router_fifo_mem #(
        .DEPTH (DEPTH),
        .DW    (WIDTH + 1),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .resetn(resetn),
        .clear (soft_reset),
        .we    (wr_fire_s),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata ({lfd_state, data_in}),
        .raddr (rd_ptr_r[AW-1:0]),
        .rdata (rd_word_s)
    );

    // Pointers wrap naturally modulo 2*DEPTH; the MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (soft_reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_fire_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Read data and packet byte count; data_out idles at zero once a packet is drained.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_out  <= '0;
            pkt_cnt_r <= '0;
        end else if (soft_reset) begin
            data_out  <= '0;
            pkt_cnt_r <= '0;
        end else if (rd_fire_s) begin
            data_out <= rd_word_s[WIDTH-1:0];
            if (rd_word_s[WIDTH]) begin
                pkt_cnt_r <= hdr_pkt_count(rd_word_s[ROUTER_DATA_W-1:0]);
            end else if (pkt_cnt_r != '0) begin
                pkt_cnt_r <= pkt_cnt_r - CNT_ONE;
            end
        end else if (!read_enb && (pkt_cnt_r == '0)) begin
            data_out <= '0;
        end
    end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of entries; SHALL be a power of two, minimum 4.
REQ-002 Parameter WIDTH, default 8, byte width of data_in/data_out; each stored word SHALL be WIDTH+1 bits, including the header flag.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 soft_reset  input  1  synchronous flush from router_sync timeout, active-high.
REQ-006 write_enb  input  1  write request for the current data_in.
REQ-007 read_enb  input  1  read request from the downstream channel.
REQ-008 lfd_state  input  1  marks data_in as a packet header byte; stored as the entry's flag bit.
REQ-009 data_in  input  WIDTH  byte from the register stage's data_out.
REQ-010 data_out  output  WIDTH  registered read data.
REQ-011 full  output  1  high when occupancy == DEPTH.
REQ-012 empty  output  1  high when occupancy == 0.

Function
REQ-013 Storage SHALL be DEPTH x (WIDTH+1); pointers SHALL be log2(DEPTH)+1 bits, with the MSB used as the wrap bit.
REQ-014 Flags: empty = (wr_ptr == rd_ptr); full = (MSBs differ AND lower bits equal); both SHALL be combinational from the pointers.
REQ-015 Write: if write_enb && !full, store {lfd_state, data_in} at wr_ptr[low] and increment wr_ptr; if full, the write SHALL be dropped with no state change.
REQ-016 Read: if read_enb && !empty, data_out SHALL equal mem[rd_ptr][WIDTH-1:0] on the next edge (one-cycle latency), and rd_ptr SHALL increment.
REQ-017 Reading a header (flag = 1) SHALL load pkt_cnt = data[7:2] + 1 (payload bytes plus parity byte).
REQ-018 Reading a non-header byte SHALL decrement pkt_cnt if pkt_cnt is nonzero.
REQ-019 When pkt_cnt reaches 0 and no read occurs, data_out SHALL return to 0 on the following edge.
REQ-020 Reading while empty SHALL be ignored; data_out SHALL hold its value.
REQ-021 Simultaneous read and write while full: the read SHALL proceed and the write SHALL be dropped (full is sampled before the edge).
REQ-022 Simultaneous read and write while empty: the write SHALL proceed and the read SHALL be ignored.
REQ-023 Simultaneous read and write otherwise: both SHALL proceed and occupancy SHALL be unchanged.
REQ-024 Pointers SHALL wrap modulo 2*DEPTH, with no special case at the address wrap.

Reset
REQ-025 resetn low SHALL asynchronously clear wr_ptr, rd_ptr, pkt_cnt, all memory words and data_out to 0; after release, empty = 1 and full = 0.
REQ-026 soft_reset high SHALL have the same effect synchronously and SHALL take priority over simultaneous write_enb and read_enb.
REQ-027 A reset asserted mid-packet SHALL discard the partial packet; no residual header flag SHALL survive.

Configuration
REQ-028 Macro ROUTER_FIFO_ALMOST_FULL_EN defined: the block SHALL add output almost_full (1 bit), high when occupancy >= DEPTH-2, combinational, reset value 0.
REQ-029 Macro ROUTER_FIFO_ALMOST_FULL_EN undefined: the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 Shared package router_pkg SHALL hold ROUTER_DATA_W = 8, ROUTER_FIFO_DEPTH = 16, ROUTER_LEN_W = 6, and the header field positions (len = [7:2], addr = [1:0]).
REQ-031 The single sub-module router_fifo_mem (a write-port/read-port register array with synchronous clear) SHALL be instantiated; pointer, flag and counter logic SHALL remain in router_fifo.

Verification
REQ-032 Reset then idle: empty = 1, full = 0, data_out = 8'h00.
REQ-033 Write header 8'h51 (lfd = 1, len 20), then 20 payload bytes and a parity byte; read 22 times -> bytes out in order, each 1 cycle after read_enb; pkt_cnt loads 21; data_out = 0 one cycle after the last byte.
REQ-034 16 writes with no reads -> full = 1; a 17th write of 8'hAA is dropped; 16 reads return the original data; empty = 1.
REQ-035 Full FIFO with read_enb and write_enb both high -> occupancy becomes 15 and the new byte is not stored; empty FIFO with both high -> occupancy becomes 1 and data_out is unchanged.
REQ-036 Eight writes then soft_reset with write_enb high -> empty = 1 next cycle and data_out = 0; a subsequent read is ignored.
REQ-037 With ROUTER_FIFO_ALMOST_FULL_EN defined: almost_full rises exactly at the 14th write and falls after the first read.
